// File: rtl/conv_ifm_feeder_if.sv
// Stream interface from the IFM feeder to the conv core input.
interface conv_ifm_feeder_if #(
   parameter int unsigned AXI_WIDTH = 128
) ();
   logic                 out_valid;
   logic                 out_ready;
   logic [AXI_WIDTH-1:0] out_data;
   logic                 out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/conv_ifm_feeder.sv
// IFM feeder: reads num_beats SRAM words starting at base_addr (stride addr_step)
// and streams them to the conv core through a 2-entry skid FIFO.
module conv_ifm_feeder #(
   parameter int unsigned AXI_WIDTH  = 128,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  start,
   input  logic                  cfg_wr_en,
   input  logic [5:0]            cfg_addr,
   input  logic [63:0]           cfg_wdata,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [AXI_WIDTH-1:0]  mem_rd_data,
   conv_ifm_feeder_if.master     out_if,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned STEP_W = 8;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   typedef struct packed {
      logic                 last;
      logic [AXI_WIDTH-1:0] data;
   } beat_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
   logic [CNT_W-1:0]      num_beats_q, num_beats_d;
   logic [STEP_W-1:0]     addr_step_q, addr_step_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;
   logic                  inflight_q, inflight_d;
   beat_t                 fifo_q [0:1];
   beat_t                 fifo_d [0:1];
   logic                  head_q, head_d;
   logic                  tail_q, tail_d;
   logic [1:0]            count_q, count_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  pop;
   logic                  push;
   logic [2:0]            occ;
   logic                  rd_en;
   logic                  unused_cfg_hi;

   // Upper config data bits have no register behind them.
   assign unused_cfg_hi = ^cfg_wdata[63:16];

   // Stream outputs come straight from the FIFO flops; never from out_ready.
   assign out_if.out_valid = (count_q != 2'd0);
   assign out_if.out_data  = fifo_q[head_q].data;
   assign out_if.out_last  = fifo_q[head_q].last;
   assign mem_rd_en        = rd_en;
   assign mem_rd_addr      = rd_ptr_q;
   assign busy             = busy_q;
   assign done             = done_q;

   // Next-state: config regs, job FSM, read issue throttle and FIFO bookkeeping.
   always_comb begin
      state_d     = state_q;
      base_addr_d = base_addr_q;
      num_beats_d = num_beats_q;
      addr_step_d = addr_step_q;
      rd_ptr_d    = rd_ptr_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      fifo_d      = fifo_q;
      head_d      = head_q;
      tail_d      = tail_q;

      pop  = (count_q != 2'd0) && out_if.out_ready;
      push = inflight_q;
      // Occupancy once this cycle's pop retires; a pop implies count_q >= 1.
      occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
      rd_en = (state_q == RUN) && (issue_cnt_q < num_beats_q) && (occ < 3'd2);
      inflight_d = rd_en;

      if (cfg_wr_en && !busy_q) begin
         case (cfg_addr)
            6'h20:   base_addr_d = cfg_wdata[ADDR_WIDTH-1:0];
            6'h21:   num_beats_d = cfg_wdata[CNT_W-1:0];
            6'h22:   addr_step_d = cfg_wdata[STEP_W-1:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_beats_q != '0) begin
                  state_d     = RUN;
                  rd_ptr_d    = base_addr_q;
                  issue_cnt_d = '0;
                  ret_cnt_d   = '0;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         RUN: begin
            if (rd_en) begin
               issue_cnt_d = issue_cnt_q + CNT_W'(1);
               rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(addr_step_q);
            end
            if (pop && fifo_q[head_q].last) begin
               state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (push) begin
         fifo_d[tail_q].data = mem_rd_data;
         fifo_d[tail_q].last = (ret_cnt_q == num_beats_q - CNT_W'(1));
         tail_d              = ~tail_q;
         ret_cnt_d           = ret_cnt_q + CNT_W'(1);
      end
      if (pop) begin
         head_d = ~head_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);

      busy_d = (state_d == RUN);
      done_d = (state_d == FINISH);
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         base_addr_q <= '0;
         num_beats_q <= '0;
         addr_step_q <= STEP_W'(1);
         rd_ptr_q    <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         fifo_q[0]   <= '0;
         fifo_q[1]   <= '0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_addr_q <= base_addr_d;
         num_beats_q <= num_beats_d;
         addr_step_q <= addr_step_d;
         rd_ptr_q    <= rd_ptr_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         inflight_q  <= inflight_d;
         fifo_q[0]   <= fifo_d[0];
         fifo_q[1]   <= fifo_d[1];
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_conv_ifm_feeder.sv
// Scoreboard bench for conv_ifm_feeder: directed jobs push expected addresses
// and beats; a negedge monitor pops and compares whatever the DUT presents.
module tb_conv_ifm_feeder;

   localparam int unsigned AW = 128;

   logic          clk       = 1'b0;
   logic          rst_b     = 1'b0;
   logic          start     = 1'b0;
   logic          cfg_wr_en = 1'b0;
   logic [5:0]    cfg_addr  = '0;
   logic [63:0]   cfg_wdata = '0;
   logic          mem_rd_en;
   logic [15:0]   mem_rd_addr;
   logic [AW-1:0] mem_rd_data = '0;
   logic          busy;
   logic          done;
   logic          tog_mode = 1'b0;

   conv_ifm_feeder_if #(.AXI_WIDTH(AW)) s_if ();

   conv_ifm_feeder #(.AXI_WIDTH(AW), .ADDR_WIDTH(16)) dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .start       (start),
      .cfg_wr_en   (cfg_wr_en),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_if      (s_if),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int issued = 0, accepted = 0, done_cnt = 0, d0 = 0;
   int first_rd = -1, last_rd = -1, first_acc = -1, last_acc = -1;
   logic          stall = 1'b0;
   logic [AW:0]   held = '0;
   logic [15:0]   addr_q [$];
   logic [AW:0]   exp_q [$];

   function automatic logic [AW-1:0] mem_f(input logic [15:0] a);
      return {a, ~a, 32'hFEED_0000 | {16'h0, a}, 64'h0123_4567_89AB_CDEF ^ {48'h0, a}};
   endfunction

   task automatic chk(input string nm, input logic [AW:0] act, input logic [AW:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // SRAM model: data one cycle after the read request.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rd_data <= mem_f(mem_rd_addr);
   end

   // Sink ready: held high, or toggling every cycle.
   initial begin
      s_if.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_mode) s_if.out_ready = ~s_if.out_ready;
         else          s_if.out_ready = 1'b1;
      end
   end

   // Monitor: compares reads and accepted beats against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst_b) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("stall_valid", (AW+1)'(s_if.out_valid), (AW+1)'(1));
            chk("stall_hold", {s_if.out_last, s_if.out_data}, held);
         end
         if (mem_rd_en) begin
            issued++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (addr_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_read: got addr %h expected none", mem_rd_addr);
            end else begin
               chk("rd_addr", (AW+1)'(mem_rd_addr), (AW+1)'(addr_q.pop_front()));
            end
         end
         if (s_if.out_valid && s_if.out_ready) begin
            accepted++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_beat: got %h expected none", s_if.out_data);
            end else begin
               chk("beat", {s_if.out_last, s_if.out_data}, exp_q.pop_front());
            end
         end
         if (busy) chk_int("outstanding_le2", int'(issued - accepted <= 2), 1);
         if (done) done_cnt++;
         stall = s_if.out_valid && !s_if.out_ready;
         held  = {s_if.out_last, s_if.out_data};
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [5:0] a, input logic [63:0] d);
      cfg_wr_en = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      step();
      cfg_wr_en = 1'b0;
   endtask

   task automatic exp_beat(input logic [15:0] a, input logic last);
      addr_q.push_back(a);
      exp_q.push_back({last, mem_f(a)});
   endtask

   task automatic expect_job(input logic [15:0] base, input logic [15:0] stp, input int n);
      for (int i = 0; i < n; i++) exp_beat(base + 16'(i) * stp, i == n - 1);
   endtask

   task automatic launch();
      issued = 0;
      accepted = 0;
      first_rd = -1;
      last_rd = -1;
      first_acc = -1;
      last_acc = -1;
      d0 = done_cnt;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int n_exp);
      int t = 0;
      while (done_cnt == d0 && t < 300) begin
         step();
         t++;
      end
      if (t >= 300) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got no done expected done within 300 cycles", nm);
      end
      step(2);
      chk_int({nm, "_beats"}, accepted, n_exp);
      chk_int({nm, "_reads"}, issued, n_exp);
      chk_int({nm, "_done_pulses"}, done_cnt - d0, 1);
      chk_int({nm, "_queue_left"}, exp_q.size(), 0);
      chk({nm, "_busy_after"}, (AW+1)'(busy), '0);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_out_valid"}, (AW+1)'(s_if.out_valid), '0);
      chk({nm, "_out_last"}, (AW+1)'(s_if.out_last), '0);
      chk({nm, "_out_data"}, (AW+1)'(s_if.out_data), '0);
      chk({nm, "_mem_rd_en"}, (AW+1)'(mem_rd_en), '0);
      chk({nm, "_busy"}, (AW+1)'(busy), '0);
      chk({nm, "_done"}, (AW+1)'(done), '0);
   endtask

   initial begin
      step(2);
      chk_reset_outputs("reset");
      rst_b = 1'b1;
      step(2);

      // Zero-beat job with reset config: done only.
      launch();
      chk("zero_done_now", (AW+1)'(done), (AW+1)'(1));
      chk("zero_busy_now", (AW+1)'(busy), '0);
      wait_done("zero", 0);

      // Basic 4-beat job, continuous ready.
      cfg(6'h21, 64'd4);
      cfg(6'h20, 64'h0010);
      expect_job(16'h0010, 16'd1, 4);
      launch();
      chk("basic_busy", (AW+1)'(busy), (AW+1)'(1));
      wait_done("basic", 4);
      chk_int("basic_read_span", last_rd - first_rd, 3);
      chk_int("basic_beat_span", last_acc - first_acc, 3);
      chk_int("basic_latency", first_acc - first_rd, 2);

      // 6 beats with toggling ready.
      cfg(6'h21, 64'd6);
      cfg(6'h20, 64'h0040);
      expect_job(16'h0040, 16'd1, 6);
      tog_mode = 1'b1;
      launch();
      wait_done("toggle", 6);
      tog_mode = 1'b0;

      // Address wrap at the top of the SRAM.
      cfg(6'h22, 64'd2);
      cfg(6'h20, 64'hFFFE);
      cfg(6'h21, 64'd3);
      exp_beat(16'hFFFE, 1'b0);
      exp_beat(16'h0000, 1'b0);
      exp_beat(16'h0002, 1'b1);
      launch();
      wait_done("wrap", 3);

      // Start and config write during a job are ignored.
      cfg(6'h22, 64'd1);
      cfg(6'h20, 64'h0100);
      cfg(6'h21, 64'd5);
      expect_job(16'h0100, 16'd1, 5);
      launch();
      step(2);
      start     = 1'b1;
      cfg_wr_en = 1'b1;
      cfg_addr  = 6'h21;
      cfg_wdata = 64'd9;
      step();
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      wait_done("midjob", 5);

      // Reset after the second beat, then a fresh job with default step.
      cfg(6'h22, 64'd4);
      cfg(6'h20, 64'h0200);
      cfg(6'h21, 64'd5);
      expect_job(16'h0200, 16'd4, 5);
      launch();
      begin
         int t = 0;
         while (accepted < 2 && t < 100) begin
            step();
            t++;
         end
         if (t >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL rst_wait: got %0d beats expected 2 within 100 cycles", accepted);
         end
      end
      rst_b = 1'b0;
      addr_q.delete();
      exp_q.delete();
      #1;
      chk_reset_outputs("midrst");
      step(2);
      chk_reset_outputs("midrst_hold");
      rst_b = 1'b1;
      step();
      cfg(6'h20, 64'h0300);
      cfg(6'h21, 64'd3);
      expect_job(16'h0300, 16'd1, 3);
      launch();
      wait_done("post_rst", 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/conv_ifm_feeder.md
CONV_IFM_FEEDER -- requirements
Module: conv_ifm_feeder

Interface
REQ-001 Parameter AXI_WIDTH, default 128, SHALL set the stream beat and SRAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16, SHALL set the SRAM word-address width.
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_b  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL be a single-cycle job launch request.
REQ-006 cfg_wr_en  input  1 / cfg_addr  input  6 / cfg_wdata  input  64  SHALL form the config write port.
REQ-007 mem_rd_en  output  1 / mem_rd_addr  output  ADDR_WIDTH  SHALL be the SRAM read request.
REQ-008 mem_rd_data  input  AXI_WIDTH  SHALL be the SRAM read data, valid exactly 1 cycle after mem_rd_en.
REQ-009 out_valid  output  1 / out_ready  input  1 / out_data  output  AXI_WIDTH / out_last  output  1  SHALL be the stream to the conv core input.
REQ-010 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-011 done  output  1  SHALL be a single-cycle completion pulse.

Function
REQ-012 Config registers: 6'h20 base_addr <= cfg_wdata[ADDR_WIDTH-1:0]; 6'h21 num_beats <= cfg_wdata[15:0]; 6'h22 addr_step <= cfg_wdata[7:0]; other addresses ignored.
REQ-013 Config writes while busy=1 SHALL be ignored; reset values: base_addr 0, num_beats 0, addr_step 1.
REQ-014 FSM states IDLE, RUN, FINISH; start is accepted only in IDLE; start in RUN or FINISH is ignored.
REQ-015 IDLE + start, num_beats!=0 -> RUN: rd_ptr <= base_addr, issue_cnt <= 0, sent_cnt <= 0, busy <= 1.
REQ-016 IDLE + start, num_beats==0 -> FINISH: no read issued, no beat emitted.
REQ-017 In RUN, mem_rd_en SHALL assert only when issue_cnt < num_beats and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready this cycle.
REQ-018 Each read increments issue_cnt; rd_ptr advances by addr_step, modulo 2^ADDR_WIDTH (wrap without error).
REQ-019 Returned data SHALL be written into a 2-entry FIFO tagged last = (beat index == num_beats-1); the FIFO never overflows.
REQ-020 out_valid = FIFO non-empty; out_data/out_last = head entry; out_data and out_last stay stable while out_valid & !out_ready.
REQ-021 Simultaneous FIFO push and pop SHALL be supported; sustained out_ready=1 SHALL yield one beat per cycle after the 2-cycle initial latency (start -> first out_valid).
REQ-022 Handshake of the out_last beat -> FINISH; FINISH lasts one cycle, asserts done, clears busy, returns to IDLE.
REQ-023 out_valid SHALL never depend combinationally on out_ready.
REQ-024 Exactly num_beats beats per job; out_last on the final beat only.

Reset
REQ-025 rst_b low SHALL force: state IDLE, FIFO empty, inflight 0, counters 0, out_valid 0, out_last 0, out_data 0, mem_rd_en 0, busy 0, done 0, config registers to their reset values.
REQ-026 Reset mid-job SHALL abandon the job; read data returning after reset release is discarded.

Verification
REQ-027 base=0x0010, step=1, beats=4, out_ready=1 -> reads 0x10..0x13 on consecutive cycles; 4 beats back-to-back, out_last on beat 4; done 1 cycle after.
REQ-028 beats=6, out_ready toggled 1/0 each cycle -> data order preserved, no beat dropped or duplicated, at most 2 unaccepted reads outstanding, data stable while stalled.
REQ-029 base=0xFFFE, step=2, beats=3 -> addresses 0xFFFE, 0x0000, 0x0002.
REQ-030 beats=0, start -> no mem_rd_en, no out_valid, done pulse, busy 0 afterwards.
REQ-031 Second start and cfg write (num_beats=9) mid-job with beats=5 -> both ignored; exactly 5 beats, one done.
REQ-032 rst_b asserted after beat 2 of 5 -> all outputs at reset values; a fresh job after release streams correct data.
